dpwm_capture: RTL

- Receive-side checker for the dithered, dead-time DPWM gate pair.
- Samples duty_high/duty_low in the fast clk domain and measures per switching period: high-side on-time, low-side on-time, both dead-time gaps and the period.
- Flags shoot-through (both gates high) and stalled gates.
- Used in closed-loop test benches and on-chip self-check to read back the duty word the modulator actually produced.

---
 rtl/dpwm_capture_pkg.sv | 20 ++
 rtl/dpwm_capture_if.sv | 40 ++++
 rtl/dpwm_capture_edge_sync.sv | 37 +++
 rtl/dpwm_capture.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/dpwm_capture_pkg.sv
// Shared types and constants for the DPWM gate-pair capture block.
package dpwm_pkg;

  typedef enum logic [2:0] {
    SYNC,
    HIGH,
    DTF,
    LOW,
    DTR
  } state_t;

  localparam int CNT_W_DEFAULT     = 8;
  localparam int DITH_BITS_DEFAULT = 3;

  // Largest value an interval counter of width w may hold before it is treated as stalled.
  function automatic int sat_limit(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/dpwm_capture_if.sv
// Gate inputs and measurement outputs of dpwm_capture; DPWM_CAPTURE_DITHER_AVG_EN adds the
// dither-averaged duty word.
interface dpwm_capture_if #(
  parameter int CNT_W     = dpwm_pkg::CNT_W_DEFAULT,
  parameter int DITH_BITS = dpwm_pkg::DITH_BITS_DEFAULT
);

  logic             duty_high;
  logic             duty_low;
  logic             fault_clr;
  logic [CNT_W-1:0] t_high;
  logic [CNT_W-1:0] t_low;
  logic [CNT_W-1:0] dt_fall;
  logic [CNT_W-1:0] dt_rise;
  logic [CNT_W-1:0] t_period;
  logic             meas_valid;
  logic             overlap_fault;
  logic             stall_fault;
`ifdef DPWM_CAPTURE_DITHER_AVG_EN
  logic [CNT_W+DITH_BITS-1:0] duty_word;
  logic                       duty_word_valid;
`endif

  modport master (
`ifdef DPWM_CAPTURE_DITHER_AVG_EN
    input  duty_word, duty_word_valid,
`endif
    output duty_high, duty_low, fault_clr,
    input  t_high, t_low, dt_fall, dt_rise, t_period, meas_valid, overlap_fault, stall_fault
  );

  modport slave (
`ifdef DPWM_CAPTURE_DITHER_AVG_EN
    output duty_word, duty_word_valid,
`endif
    input  duty_high, duty_low, fault_clr,
    output t_high, t_low, dt_fall, dt_rise, t_period, meas_valid, overlap_fault, stall_fault
  );

endinterface

// File: rtl/dpwm_capture_edge_sync.sv
// Registers the gate pair once and derives rising/falling edges from the registered samples.
module dpwm_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic duty_high,
  input  logic duty_low,
  output logic h_q,
  output logic l_q,
  output logic h_rise,
  output logic h_fall,
  output logic l_rise,
  output logic l_fall
);

  logic h_p;
  logic l_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q <= 1'b0;
      l_q <= 1'b0;
      h_p <= 1'b0;
      l_p <= 1'b0;
    end else begin
      h_q <= duty_high;
      l_q <= duty_low;
      h_p <= h_q;
      l_p <= l_q;
    end
  end

  assign h_rise = h_q & ~h_p;
  assign h_fall = ~h_q & h_p;
  assign l_rise = l_q & ~l_p;
  assign l_fall = ~l_q & l_p;

endmodule

// File: rtl/dpwm_capture.sv
// Measures on-times, dead times and period of a DPWM gate pair and flags overlap/stall.
// Optional macro DPWM_CAPTURE_DITHER_AVG_EN adds a t_high sum over 2^DITH_BITS periods.
module dpwm_capture #(
  parameter int CNT_W     = dpwm_pkg::CNT_W_DEFAULT,
  parameter int DITH_BITS = dpwm_pkg::DITH_BITS_DEFAULT
) (
  input logic           clk,
  input logic           rst,
  dpwm_capture_if.slave bus
);

  import dpwm_pkg::*;

  localparam logic [CNT_W-1:0] SAT     = CNT_W'(sat_limit(CNT_W));
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == SAT) ? v : v + CNT_ONE;
  endfunction

  logic h_q, l_q, h_rise, h_fall, l_rise, l_fall;

  dpwm_edge_sync u_edge (
    .clk       (clk),
    .rst       (rst),
    .duty_high (bus.duty_high),
    .duty_low  (bus.duty_low),
    .h_q       (h_q),
    .l_q       (l_q),
    .h_rise    (h_rise),
    .h_fall    (h_fall),
    .l_rise    (l_rise),
    .l_fall    (l_fall)
  );

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt_high, cnt_dtf, cnt_low, cnt_dtr, cnt_per;
  logic [CNT_W-1:0] cnt_high_n, cnt_dtf_n, cnt_low_n, cnt_dtr_n, cnt_per_n;
  logic             vld_p0;
  logic             start_period;
  logic             ovl_hit;
  logic             sat_hit;
  logic             ovl_q;
  logic             stall_q;

  // Stage p0: interval FSM on the registered gate samples
  always_comb begin
    state_n      = state;
    cnt_high_n   = cnt_high;
    cnt_dtf_n    = cnt_dtf;
    cnt_low_n    = cnt_low;
    cnt_dtr_n    = cnt_dtr;
    cnt_per_n    = (state == SYNC) ? cnt_per : sat_inc(cnt_per);
    vld_p0       = 1'b0;
    start_period = 1'b0;
    ovl_hit      = h_q & l_q;
    sat_hit      = (state != SYNC) &&
                   ((cnt_high == SAT) || (cnt_dtf == SAT) || (cnt_low == SAT) ||
                    (cnt_dtr == SAT) || (cnt_per == SAT));

    if (ovl_hit || sat_hit) begin
      state_n = SYNC;
    end else begin
      case (state)
        SYNC: begin
          if (h_rise) start_period = 1'b1;
        end
        HIGH: begin
          if (h_fall && l_rise) begin
            state_n   = LOW;
            cnt_low_n = CNT_ONE;
          end else if (h_fall) begin
            state_n   = DTF;
            cnt_dtf_n = CNT_ONE;
          end else begin
            cnt_high_n = sat_inc(cnt_high);
          end
        end
        DTF: begin
          if (h_rise) begin
            state_n = SYNC;
          end else if (l_rise) begin
            state_n   = LOW;
            cnt_low_n = CNT_ONE;
          end else begin
            cnt_dtf_n = sat_inc(cnt_dtf);
          end
        end
        LOW: begin
          // Zero rising dead time: the period closes straight from LOW with dt_rise still 0.
          if (l_fall && h_rise) begin
            vld_p0       = 1'b1;
            start_period = 1'b1;
          end else if (l_fall) begin
            state_n   = DTR;
            cnt_dtr_n = CNT_ONE;
          end else begin
            cnt_low_n = sat_inc(cnt_low);
          end
        end
        DTR: begin
          if (h_rise) begin
            vld_p0       = 1'b1;
            start_period = 1'b1;
          end else if (l_rise) begin
            state_n = SYNC;
          end else begin
            cnt_dtr_n = sat_inc(cnt_dtr);
          end
        end
        default: state_n = SYNC;
      endcase
    end

    // The edge-detect cycle is the first counted cycle of the new high phase.
    if (start_period) begin
      state_n    = HIGH;
      cnt_high_n = CNT_ONE;
      cnt_dtf_n  = '0;
      cnt_low_n  = '0;
      cnt_dtr_n  = '0;
      cnt_per_n  = CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SYNC;
      cnt_high <= '0;
      cnt_dtf  <= '0;
      cnt_low  <= '0;
      cnt_dtr  <= '0;
      cnt_per  <= '0;
    end else begin
      state    <= state_n;
      cnt_high <= cnt_high_n;
      cnt_dtf  <= cnt_dtf_n;
      cnt_low  <= cnt_low_n;
      cnt_dtr  <= cnt_dtr_n;
      cnt_per  <= cnt_per_n;
    end
  end

  // Stage p1: published measurements and sticky faults
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.t_high     <= '0;
      bus.dt_fall    <= '0;
      bus.t_low      <= '0;
      bus.dt_rise    <= '0;
      bus.t_period   <= '0;
      bus.meas_valid <= 1'b0;
      ovl_q          <= 1'b0;
      stall_q        <= 1'b0;
    end else begin
      bus.meas_valid <= vld_p0;
      if (vld_p0) begin
        bus.t_high   <= cnt_high;
        bus.dt_fall  <= cnt_dtf;
        bus.t_low    <= cnt_low;
        bus.dt_rise  <= cnt_dtr;
        bus.t_period <= cnt_per;
      end
      ovl_q   <= (ovl_q & ~bus.fault_clr) | ovl_hit;
      stall_q <= (stall_q & ~bus.fault_clr) | sat_hit;
    end
  end

  assign bus.overlap_fault = ovl_q;
  assign bus.stall_fault   = stall_q;

`ifdef DPWM_CAPTURE_DITHER_AVG_EN
  localparam int AW = CNT_W + DITH_BITS;

  logic [AW-1:0]        acc;
  logic [DITH_BITS-1:0] frame;
  logic [AW-1:0]        acc_sum;
  logic                 sync_entry;

  assign acc_sum    = acc + {{DITH_BITS{1'b0}}, cnt_high};
  assign sync_entry = (state_n == SYNC) && (state != SYNC);

  // A frame restarts whenever tracking is lost so partial sums never mix across resyncs.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc                 <= '0;
      frame               <= '0;
      bus.duty_word       <= '0;
      bus.duty_word_valid <= 1'b0;
    end else begin
      bus.duty_word_valid <= 1'b0;
      if (sync_entry) begin
        acc   <= '0;
        frame <= '0;
      end else if (vld_p0) begin
        if (&frame) begin
          bus.duty_word       <= acc_sum;
          bus.duty_word_valid <= 1'b1;
          acc                 <= '0;
          frame               <= '0;
        end else begin
          acc   <= acc_sum;
          frame <= frame + 1'b1;
        end
      end
    end
  end
`endif

endmodule
